// File: rtl/boot_pkg.sv
// Shared definitions for the boot image selector: FSM encoding, default flash
// layout and the image address helper.
package boot_pkg;

  localparam logic [23:0] DEFAULT_IMAGE_STRIDE = 24'h054000;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_DECIDE,
    ST_HOLD,
    ST_REQUEST,
    ST_DONE
  } boot_state_t;

  // (sel + 1) * stride written as shifts and adds so no multiplier is inferred.
  function automatic logic [23:0] image_addr(input logic [1:0] sel, input logic [23:0] stride);
    logic [23:0] addr;
    case (sel)
      2'd0:    addr = stride;
      2'd1:    addr = stride << 1;
      2'd2:    addr = (stride << 1) + stride;
      default: addr = stride << 2;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/boot_debounce.sv
// Two-flop synchronizer followed by a hold-steady debouncer for one raw
// asynchronous input.
module boot_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic clean
);

  logic        sync_q1;
  logic        sync_q2;
  logic [15:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Any cycle where the synchronized input agrees with the output restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 16'd0;
      clean <= 1'b0;
    end else if (sync_q2 != clean) begin
      if (count == DEBOUNCE_CYCLES - 16'd1) begin
        clean <= sync_q2;
        count <= 16'd0;
      end else begin
        count <= count + 16'd1;
      end
    end else begin
      count <= 16'd0;
    end
  end

endmodule

// File: rtl/boot_image_select.sv
// Chooses a flash boot image from debounced DIP switches and hands a reboot
// request to the ICAP sequencer, with manual reboot and ack timeout handling.
module boot_image_select
  import boot_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [19:0] SETTLE_CYCLES   = 20'd800000,
  parameter logic [23:0] IMAGE_STRIDE    = DEFAULT_IMAGE_STRIDE,
  parameter logic [15:0] ACK_TIMEOUT     = 16'd1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  dip,
  input  logic        boot_key,
  output logic        req,
  input  logic        ack,
  output logic [23:0] boot_addr,
  output logic        err,
  output logic        led
);

  logic [3:0]  dip_deb;
  logic        key_deb;
  logic        key_prev;
  logic        manual;
  logic        manual_next;
  logic        dip2_unused;
  boot_state_t state;
  boot_state_t state_next;
  logic [19:0] count;
  logic [19:0] count_next;
  logic [23:0] addr_next;
  logic        err_next;

  for (genvar i = 0; i < 4; i++) begin : g_dip
    boot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dip_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (dip[i]),
      .clean   (dip_deb[i])
    );
  end

  boot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_deb (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (boot_key),
    .clean   (key_deb)
  );

  // dip[2] is debounced like its neighbours but carries no function yet.
  assign dip2_unused = dip_deb[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_SETTLE;
      count     <= 20'd0;
      boot_addr <= 24'h000000;
      err       <= 1'b0;
      key_prev  <= 1'b0;
      manual    <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      boot_addr <= addr_next;
      err       <= err_next;
      key_prev  <= key_deb;
      manual    <= manual_next;
    end
  end

  // One counter serves both the settle delay and the ack timeout; it is
  // cleared on every state change so each phase starts from zero.
  always_comb begin
    state_next  = state;
    count_next  = count;
    addr_next   = boot_addr;
    err_next    = err;
    manual_next = manual;
    case (state)
      ST_SETTLE: begin
        if (count == SETTLE_CYCLES) begin
          state_next = ST_DECIDE;
          count_next = 20'd0;
        end else begin
          count_next = count + 20'd1;
        end
      end
      ST_DECIDE: begin
        addr_next  = image_addr(dip_deb[1:0], IMAGE_STRIDE);
        count_next = 20'd0;
        state_next = (manual || !dip_deb[3]) ? ST_REQUEST : ST_HOLD;
      end
      ST_HOLD: begin
        if (key_deb && !key_prev) begin
          state_next  = ST_DECIDE;
          manual_next = 1'b1;
        end
      end
      ST_REQUEST: begin
        if (ack) begin
          state_next = ST_DONE;
          count_next = 20'd0;
        end else if (count == {4'd0, ACK_TIMEOUT} - 20'd1) begin
          state_next = ST_HOLD;
          err_next   = 1'b1;
          count_next = 20'd0;
        end else begin
          count_next = count + 20'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_SETTLE;
        count_next = 20'd0;
      end
    endcase
  end

  // Decoded straight from the state register so reset drops req at once.
  assign req = (state == ST_REQUEST);
  assign led = (state == ST_HOLD);

endmodule

// File: tb/tb_boot_image_select.sv
// Directed bench for boot_image_select: drives each verification scenario
// from the specification and compares outputs at the exact required cycles.
module tb_boot_image_select;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  dip;
   logic        bootKey;
   logic        ack;
   logic        req;
   logic [23:0] bootAddr;
   logic        err;
   logic        led;

   int checks = 0;
   int errors = 0;
   int stimCyc = 0;

   always #5 clock = ~clock;

   boot_image_select #(
      .DEBOUNCE_CYCLES (16'd4),
      .SETTLE_CYCLES   (20'd16),
      .IMAGE_STRIDE    (24'h054000),
      .ACK_TIMEOUT     (16'd8)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .dip       (dip),
      .boot_key  (bootKey),
      .req       (req),
      .ack       (ack),
      .boot_addr (bootAddr),
      .err       (err),
      .led       (led)
   );

   // Compares every output against the required values at the current cycle.
   task automatic checkOutput(input string name, input logic expReq, input logic expLed,
                              input logic expErr, input logic [23:0] expAddr);
      checks++;
      if (req !== expReq) begin
         errors++;
         $display("[TB] FAIL %s: got req=%b, required req=%b (cycle %0d)", name, req, expReq, stimCyc);
      end
      checks++;
      if (led !== expLed) begin
         errors++;
         $display("[TB] FAIL %s: got led=%b, required led=%b (cycle %0d)", name, led, expLed, stimCyc);
      end
      checks++;
      if (err !== expErr) begin
         errors++;
         $display("[TB] FAIL %s: got err=%b, required err=%b (cycle %0d)", name, err, expErr, stimCyc);
      end
      checks++;
      if (bootAddr !== expAddr) begin
         errors++;
         $display("[TB] FAIL %s: got boot_addr=%h, required boot_addr=%h (cycle %0d)",
                  name, bootAddr, expAddr, stimCyc);
      end
   endtask

   // Advances to the falling edge after rising edge n counted from reset release.
   task automatic waitCycle(input int n);
      repeat (n - stimCyc) @(negedge clock);
      stimCyc = n;
   endtask

   // Asserts reset shortly after a rising edge, checks that outputs clear at
   // once, and releases it between edges so the next rising edge is cycle 1.
   task automatic applyReset(input logic [3:0] dipVal);
      @(posedge clock);
      #2 reset_n = 1'b0;
      dip     = dipVal;
      bootKey = 1'b0;
      ack     = 1'b0;
      #1;
      checks++;
      if ({req, led, err, bootAddr} !== 27'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: got req=%b led=%b err=%b addr=%h, required all 0",
                  req, led, err, bootAddr);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      stimCyc = 0;
   endtask

   // Runs all verification scenarios in sequence.
   task automatic applyStimulus();
      applyReset(4'b0001);
      waitCycle(17);
      checkOutput("A_before_req", 1'b0, 1'b0, 1'b0, 24'h000000);
      waitCycle(18);
      checkOutput("A_req_rise", 1'b1, 1'b0, 1'b0, 24'h0A8000);
      waitCycle(19); dip = 4'b0010;
      waitCycle(20); ack = 1'b1;
      checkOutput("A_req_held", 1'b1, 1'b0, 1'b0, 24'h0A8000);
      waitCycle(21); ack = 1'b0;
      checkOutput("A_ack_done", 1'b0, 1'b0, 1'b0, 24'h0A8000);
      waitCycle(24); ack = 1'b1;
      waitCycle(25); ack = 1'b0; bootKey = 1'b1;
      waitCycle(35); bootKey = 1'b0;
      waitCycle(42);
      checkOutput("A_done_terminal", 1'b0, 1'b0, 1'b0, 24'h0A8000);

      applyReset(4'b1011);
      waitCycle(18);
      checkOutput("B_hold", 1'b0, 1'b1, 1'b0, 24'h150000);
      waitCycle(25); bootKey = 1'b1;
      waitCycle(28); bootKey = 1'b0;
      waitCycle(40);
      checkOutput("B_glitch_ignored", 1'b0, 1'b1, 1'b0, 24'h150000);
      bootKey = 1'b1;
      waitCycle(47);
      checkOutput("B_decide", 1'b0, 1'b0, 1'b0, 24'h150000);
      waitCycle(48);
      checkOutput("B_manual_req", 1'b1, 1'b0, 1'b0, 24'h150000);
      for (int c = 49; c < 56; c++) begin
         waitCycle(c);
         if (c == 50) bootKey = 1'b0;
         checks++;
         if (req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL B_req_window: got req=%b, required req=1 (cycle %0d)", req, c);
         end
      end
      waitCycle(56);
      checkOutput("B_timeout", 1'b0, 1'b1, 1'b1, 24'h150000);
      waitCycle(58); ack = 1'b1;
      waitCycle(59); ack = 1'b0;
      waitCycle(64);
      checkOutput("B_late_ack_ignored", 1'b0, 1'b1, 1'b1, 24'h150000);

      applyReset(4'b0000);
      waitCycle(18);
      checkOutput("C_req_rise", 1'b1, 1'b0, 1'b0, 24'h054000);
      for (int c = 19; c < 26; c++) begin
         waitCycle(c);
         checks++;
         if (req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL C_req_window: got req=%b, required req=1 (cycle %0d)", req, c);
         end
      end
      waitCycle(26);
      checkOutput("C_timeout", 1'b0, 1'b1, 1'b1, 24'h054000);

      applyReset(4'b0000);
      waitCycle(18);
      checkOutput("D_req_rise", 1'b1, 1'b0, 1'b0, 24'h054000);
      waitCycle(25); ack = 1'b1;
      waitCycle(26); ack = 1'b0;
      checkOutput("D_ack_last", 1'b0, 1'b0, 1'b0, 24'h054000);
      waitCycle(30);
      checkOutput("D_done_stays", 1'b0, 1'b0, 1'b0, 24'h054000);

      applyReset(4'b0001);
      waitCycle(18);
      checkOutput("E_req_rise", 1'b1, 1'b0, 1'b0, 24'h0A8000);
      waitCycle(19);
      applyReset(4'b0001);
      waitCycle(17);
      checkOutput("E_restart_settle", 1'b0, 1'b0, 1'b0, 24'h000000);
      waitCycle(18);
      checkOutput("E_restart_req", 1'b1, 1'b0, 1'b0, 24'h0A8000);
      waitCycle(20); ack = 1'b1;
      waitCycle(21); ack = 1'b0;
      checkOutput("E_restart_done", 1'b0, 1'b0, 1'b0, 24'h0A8000);
      waitCycle(26);
   endtask

   // Watchdog in case the stimulus never completes.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no end of stimulus, required finish within 100000ns");
      $fatal(1);
   end

   // Main sequence: run all scenarios, then print the summary.
   initial begin
      reset_n = 1'b1;
      dip     = 4'b0000;
      bootKey = 1'b0;
      ack     = 1'b0;
      $display("[TB] boot_image_select directed run starting");
      applyStimulus();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/boot_image_select.md
BOOT_IMAGE_SELECT -- requirements
Module: boot_image_select

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000, cycles an input must hold steady to be accepted.
REQ-002 Parameter SETTLE_CYCLES, default 20'd800000, post-reset delay before first autoboot decision.
REQ-003 Parameter IMAGE_STRIDE, default 24'h054000, flash byte spacing between images.
REQ-004 Parameter ACK_TIMEOUT, default 16'd1024, cycles to wait for ack before withdrawing request.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  system clock, all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 dip  input  4  raw asynchronous switches; dip[1:0] image select, dip[3] autoboot inhibit, dip[2] unused.
REQ-009 boot_key  input  1  raw asynchronous pushbutton, active high, manual reboot.
REQ-010 req  output  1  reboot request to downstream ICAP sequencer.
REQ-011 ack  input  1  single-cycle acceptance pulse from ICAP sequencer.
REQ-012 boot_addr  output  24  flash byte address of selected image, valid while req=1.
REQ-013 err  output  1  sticky flag, a request timed out.
REQ-014 led  output  1  1 while waiting in HOLD, 0 otherwise.

Function
REQ-015 Each of dip[3:0] and boot_key SHALL pass a 2-flop synchronizer, then its own debouncer.
REQ-016 Debounced value SHALL update only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to old value restarts that input's count.
REQ-017 Debounced values SHALL reset to 0.
REQ-018 States: SETTLE, DECIDE, HOLD, REQUEST, DONE.
REQ-019 SETTLE: count SETTLE_CYCLES cycles, then DECIDE.
REQ-020 DECIDE, one cycle: latch boot_addr = (debounced dip[1:0] + 1) * IMAGE_STRIDE, 24-bit, no overflow for defaults; go REQUEST if debounced dip[3]=0, else HOLD.
REQ-021 HOLD: on rising edge of debounced boot_key, go DECIDE; debounced dip[3] is ignored in this path.
REQ-022 REQUEST: req=1, boot_addr constant; ack=1 -> DONE next cycle, req=0 on that cycle.
REQ-023 REQUEST timeout: ACK_TIMEOUT cycles without ack -> req=0, err=1, go HOLD.
REQ-024 ack coincident with timeout cycle SHALL win: go DONE, err unchanged.
REQ-025 ack outside REQUEST SHALL be ignored.
REQ-026 DONE is terminal until reset; req=0.
REQ-027 Changes on dip after DECIDE SHALL NOT alter boot_addr until next DECIDE.
REQ-028 Latency: autoboot asserts req exactly SETTLE_CYCLES+2 cycles after reset_n release, given stable debounced inputs.

Reset
REQ-029 reset_n low, any state: state=SETTLE, counters=0, req=0, boot_addr=24'h000000, err=0, led=0, synchronizers and debouncers=0.
REQ-030 Reset asserted mid-REQUEST SHALL drop req immediately, asynchronously.
REQ-031 Reset deassertion SHALL be used as-is; no internal resynchronization of reset_n.

Structure
REQ-032 State encoding and default IMAGE_STRIDE SHALL live in shared package boot_pkg.
REQ-033 Debouncer SHALL be sub-module boot_debounce (sync + counter), instantiated five times.
REQ-034 Multiplication SHALL be synthesized as constant-stride arithmetic, no DSP requirement.

Verification (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=16, ACK_TIMEOUT=8)
REQ-035 dip=4'b0001 stable, ack 3 cycles after req -> req at cycle 18, boot_addr=24'h0A8000, DONE, err=0.
REQ-036 dip=4'b1011 -> HOLD, led=1; boot_key high 10 cycles -> req, boot_addr=24'h150000.
REQ-037 dip=0, no ack -> req high 8 cycles, then req=0, err=1, led=1.
REQ-038 boot_key glitch 3 cycles high -> no transition out of HOLD.
REQ-039 dip=0, ack on final timeout cycle -> DONE, err=0, boot_addr=24'h054000.
REQ-040 reset_n low during REQUEST -> req=0 same cycle, restarts SETTLE with all outputs 0.
